// File: rtl/z8_uart_pkg.sv
// Shared definitions for the z8_uart serial block: FSM state encodings and parity helper.
// The optional parity bit is enabled with the Z8_UART_PARITY_EN macro.
package z8_uart_pkg;

  localparam logic [2:0] UART_IDLE   = 3'd0;
  localparam logic [2:0] UART_START  = 3'd1;
  localparam logic [2:0] UART_DATA   = 3'd2;
  localparam logic [2:0] UART_PARITY = 3'd3;
  localparam logic [2:0] UART_STOP   = 3'd4;
  localparam logic [2:0] UART_WAIT   = 3'd5;

  // Even parity over up to 9 payload bits (unused upper bits must be zero).
  function automatic logic even_parity9(input logic [8:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/z8_uart_fifo.sv
// Synchronous FIFO used for both the TX and RX queues of z8_uart.
// A push while full is honoured only when a pop frees a slot in the same cycle; no empty bypass.
module z8_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop_ok)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/z8_uart.sv
// Parametrised full-duplex UART with TX/RX FIFOs, overrun and framing detection.
// Define Z8_UART_PARITY_EN to add an even-parity bit after the data on both directions.
module z8_uart
  import z8_uart_pkg::*;
#(
  parameter int CLK_DIV    = 104,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 serialIn,
  output logic                 serialOut,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 err_clr,
  output logic                 rx_overrun,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int              CW        = $clog2(CLK_DIV);
  localparam int              BW        = 4;
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]   DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0]   BIT_ONE   = BW'(1);
  localparam logic [BW-1:0]   DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0]   STOP_LAST = BW'(STOP_BITS - 1);

  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_pop;
  logic                 tx_term;
  logic [2:0]           tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_line;

  logic                 rx_full;
  logic                 rx_empty;
  logic                 rx_push;
  logic                 rx_term;
  logic                 rx_keep;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic [2:0]           rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 ovr_set;
  logic                 frm_set;

  assign serialOut = tx_line;
  assign tx_ready  = !tx_full;
  assign rx_valid  = !rx_empty;

  z8_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_valid && !tx_full), .wdata(tx_data),
    .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  z8_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .wdata(rx_shift),
    .pop(rx_ready), .rdata(rx_data), .full(rx_full), .empty(rx_empty)
  );

  // ---------------------------------------------------------------- transmit
  assign tx_term = (tx_cnt == DIV_LAST);

  // A frame starts from IDLE, or directly from the end of STOP so queued frames run gap-free.
  always_comb begin
    tx_pop = 1'b0;
    if (!tx_empty && ((tx_state == UART_IDLE) ||
        ((tx_state == UART_STOP) && tx_term && (tx_bit == STOP_LAST)))) begin
      tx_pop = 1'b1;
    end else begin
      tx_pop = 1'b0;
    end
  end

`ifdef Z8_UART_PARITY_EN
  logic tx_par;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx_par <= 1'b0;
    else if (tx_pop) tx_par <= even_parity9(9'(tx_head));
    else tx_par <= tx_par;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= UART_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        UART_IDLE: begin
          tx_cnt <= '0;
          tx_bit <= '0;
          if (tx_pop) begin
            tx_state <= UART_START;
            tx_shift <= tx_head;
            tx_line  <= 1'b0;
          end
        end
        UART_START: begin
          if (tx_term) begin
            tx_cnt   <= '0;
            tx_state <= UART_DATA;
            tx_line  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
        UART_DATA: begin
          if (tx_term) begin
            tx_cnt <= '0;
            if (tx_bit == DATA_LAST) begin
              tx_bit <= '0;
`ifdef Z8_UART_PARITY_EN
              tx_state <= UART_PARITY;
              tx_line  <= tx_par;
`else
              tx_state <= UART_STOP;
              tx_line  <= 1'b1;
`endif
            end else begin
              tx_bit   <= tx_bit + BIT_ONE;
              tx_line  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
`ifdef Z8_UART_PARITY_EN
        UART_PARITY: begin
          if (tx_term) begin
            tx_cnt   <= '0;
            tx_state <= UART_STOP;
            tx_line  <= 1'b1;
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
`endif
        UART_STOP: begin
          if (tx_term) begin
            tx_cnt <= '0;
            if (tx_bit == STOP_LAST) begin
              tx_bit <= '0;
              if (tx_pop) begin
                tx_state <= UART_START;
                tx_shift <= tx_head;
                tx_line  <= 1'b0;
              end else tx_state <= UART_IDLE;
            end else tx_bit <= tx_bit + BIT_ONE;
          end else tx_cnt <= tx_cnt + CNT_ONE;
        end
        default: begin
          tx_state <= UART_IDLE;
          tx_line  <= 1'b1;
        end
      endcase
    end
  end

  // ----------------------------------------------------------------- receive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= serialIn;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_term = (rx_state == UART_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == DIV_LAST);

`ifdef Z8_UART_PARITY_EN
  logic rx_bad;
  logic par_set;

  assign par_set = (rx_state == UART_PARITY) && rx_term &&
                   (rx_sync != even_parity9(9'(rx_shift)));
  assign rx_keep = !rx_bad;

  // A parity mismatch marks the frame for discard at its stop bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_bad <= 1'b0;
    else if (rx_state == UART_IDLE) rx_bad <= 1'b0;
    else if (par_set) rx_bad <= 1'b1;
    else rx_bad <= rx_bad;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_parity_err <= 1'b0;
    else if (par_set) rx_parity_err <= 1'b1;
    else if (err_clr) rx_parity_err <= 1'b0;
    else rx_parity_err <= rx_parity_err;
  end
`else
  assign rx_keep       = 1'b1;
  assign rx_parity_err = 1'b0;
`endif

  always_comb begin
    rx_push = 1'b0;
    ovr_set = 1'b0;
    frm_set = 1'b0;
    if ((rx_state == UART_STOP) && rx_term) begin
      if (!rx_sync) frm_set = 1'b1;
      else if (rx_keep) begin
        rx_push = 1'b1;
        ovr_set = rx_full && !rx_ready;
      end else begin
        rx_push = 1'b0;
      end
    end else begin
      rx_push = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= UART_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        UART_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_prev && !rx_sync) rx_state <= UART_START;
        end
        UART_START: begin
          if (rx_term) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? UART_IDLE : UART_DATA;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        UART_DATA: begin
          if (rx_term) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == DATA_LAST) begin
              rx_bit <= '0;
`ifdef Z8_UART_PARITY_EN
              rx_state <= UART_PARITY;
`else
              rx_state <= UART_STOP;
`endif
            end else rx_bit <= rx_bit + BIT_ONE;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
`ifdef Z8_UART_PARITY_EN
        UART_PARITY: begin
          if (rx_term) begin
            rx_cnt   <= '0;
            rx_state <= UART_STOP;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
`endif
        // Only the first stop bit is checked; a low one waits for an idle line.
        UART_STOP: begin
          if (rx_term) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? UART_IDLE : UART_WAIT;
          end else rx_cnt <= rx_cnt + CNT_ONE;
        end
        UART_WAIT: begin
          if (rx_sync) rx_state <= UART_IDLE;
        end
        default: rx_state <= UART_IDLE;
      endcase
    end
  end

  // Sticky error flags: a same-cycle set beats err_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (ovr_set) rx_overrun <= 1'b1;
      else if (err_clr) rx_overrun <= 1'b0;
      else rx_overrun <= rx_overrun;
      if (frm_set) rx_frame_err <= 1'b1;
      else if (err_clr) rx_frame_err <= 1'b0;
      else rx_frame_err <= rx_frame_err;
    end
  end

endmodule

// File: tb/tb_z8_uart.sv
// Randomised self-checking bench for z8_uart (CLK_DIV=4, 8 data bits, 1 stop bit, 4-deep FIFOs).
// Expected line waveforms and received bytes come from a frame-level reference model.
module tb_z8_uart;

  localparam int DIV = 4;
`ifdef Z8_UART_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       serialIn = 1'b1;
  logic       serialOut;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rx_parity_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] rx_model[$];

  z8_uart #(.CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .serialIn(serialIn), .serialOut(serialOut),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .err_clr(err_clr), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Line bits of one frame, bit i sent i-th: start, data LSB first, [parity], stop.
  function automatic logic [15:0] make_frame(input logic [7:0] d, input logic stop);
`ifdef Z8_UART_PARITY_EN
    return {5'b0, stop, ^d, d, 1'b0};
`else
    return {6'b0, stop, d, 1'b0};
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out"}, {31'd0, serialOut}, 32'd1);
    check({tag, "_rdy"}, {31'd0, tx_ready}, 32'd1);
    check({tag, "_rxv"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_flags"}, {29'd0, rx_overrun, rx_frame_err, rx_parity_err}, 32'd0);
  endtask

  // Push n bytes on consecutive cycles and compare serialOut sample by sample.
  task automatic tx_burst(input int n, input logic [7:0] first);
    logic [7:0] b[5];
    logic       exp_line[$];
    logic [15:0] f;
    for (int i = 0; i < n; i++) b[i] = (i == 0) ? first : 8'($urandom);
    exp_line.push_back(1'b1);
    for (int i = 0; i < n; i++) begin
      f = make_frame(b[i], 1'b1);
      for (int j = 0; j < FLEN; j++)
        for (int k = 0; k < DIV; k++) exp_line.push_back(f[j]);
    end
    for (int k = 0; k < 2 * DIV; k++) exp_line.push_back(1'b1);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          tx_data  = b[i];
          tx_valid = 1'b1;
          check("tx_ready_pre", {31'd0, tx_ready}, {31'd0, ((i - ((i >= 2) ? 1 : 0)) < 4)});
          @(posedge clk);
          @(negedge clk);
        end
        tx_valid = 1'b0;
        check("tx_ready_post", {31'd0, tx_ready}, {31'd0, ((n - ((n >= 2) ? 1 : 0)) < 4)});
      end
      begin
        @(posedge clk);
        foreach (exp_line[k]) begin
          @(negedge clk);
          check("tx_line", {31'd0, serialOut}, {31'd0, exp_line[k]});
        end
      end
    join
  endtask

  // Drive one frame on serialIn; the model keeps the byte when it is a clean frame with room.
  task automatic rx_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    logic [15:0] f;
    f = make_frame(d, stop);
    if (bad_par) f = f ^ (16'd1 << 9);
    for (int j = 0; j < FLEN; j++) begin
      serialIn = f[j];
      repeat (DIV) @(negedge clk);
    end
    serialIn = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    if (stop && !bad_par && rx_model.size() < 4) rx_model.push_back(d);
  endtask

  task automatic rx_pop_check(input string tag);
    check({tag, "_valid"}, {31'd0, rx_valid}, {31'd0, rx_model.size() != 0});
    if (rx_model.size() != 0) begin
      check({tag, "_data"}, {24'd0, rx_data}, {24'd0, rx_model[0]});
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      void'(rx_model.pop_front());
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("rst_hold");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("rst_rel");

    // Transmit: A5 first, then random singles and a 5-byte back-to-back burst
    tx_burst(1, 8'hA5);
    for (int r = 0; r < 3; r++) tx_burst(1, 8'($urandom));
    tx_burst(5, 8'($urandom));
    check("tx_drained", {31'd0, tx_ready}, 32'd1);

    // Asynchronous reset in the middle of an all-zero data phase
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = !serialOut;
    end
    check("midtx_start_seen", {31'd0, seen}, 32'd1);
    repeat (6) @(negedge clk);
    check("midtx_low", {31'd0, serialOut}, 32'd0);
    #2 reset_n = 1'b0;
    #1 check("midtx_async_high", {31'd0, serialOut}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("midtx_after");

    // Receive 8'h3C, then a few random bytes, popping each
    rx_frame(8'h3C, 1'b1, 1'b0);
    rx_pop_check("rx3c");
    check("rx3c_empty", {31'd0, rx_valid}, 32'd0);
    for (int r = 0; r < 4; r++) begin
      rx_frame(8'($urandom), 1'b1, 1'b0);
      rx_pop_check("rxrand");
    end
    check("rxrand_empty", {31'd0, rx_valid}, 32'd0);

    // Overrun: five frames with no pops
    for (int r = 0; r < 4; r++) rx_frame(8'($urandom), 1'b1, 1'b0);
    check("ovr_before", {31'd0, rx_overrun}, 32'd0);
    rx_frame(8'($urandom), 1'b1, 1'b0);
    check("ovr_set", {31'd0, rx_overrun}, 32'd1);
    for (int r = 0; r < 4; r++) rx_pop_check("ovr_order");
    check("ovr_empty", {31'd0, rx_valid}, 32'd0);
    pulse_clr();
    check("ovr_clr", {31'd0, rx_overrun}, 32'd0);

    // Framing error: stop bit low
    rx_frame(8'($urandom), 1'b0, 1'b0);
    check("frm_set", {31'd0, rx_frame_err}, 32'd1);
    check("frm_nopush", {31'd0, rx_valid}, 32'd0);
    pulse_clr();
    check("frm_clr", {31'd0, rx_frame_err}, 32'd0);

    // One-cycle glitch must not start a frame
    serialIn = 1'b0;
    @(negedge clk);
    serialIn = 1'b1;
    repeat (FLEN * DIV + 8) @(negedge clk);
    check("glitch_nopush", {31'd0, rx_valid}, 32'd0);
    check("glitch_noerr", {31'd0, rx_frame_err}, 32'd0);
    rx_frame(8'($urandom), 1'b1, 1'b0);
    rx_pop_check("post_glitch");

`ifdef Z8_UART_PARITY_EN
    rx_frame(8'($urandom), 1'b1, 1'b1);
    check("par_set", {31'd0, rx_parity_err}, 32'd1);
    check("par_nopush", {31'd0, rx_valid}, 32'd0);
    pulse_clr();
    check("par_clr", {31'd0, rx_parity_err}, 32'd0);
`else
    check("par_tied", {31'd0, rx_parity_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
